cfa_window_assembler: RTL

- Sits on the read-data side of the CFA pipeline and consumes the sample stream that the frame addresser's reads return.
- Builds a filterSize×filterSize pixel window per output pixel, substituting zero for out-of-frame samples.
- Presents each window to the demosaic datapath with a valid/ready handshake, and drives the addresser's `en` stall input so the addresser stalls at column boundaries.

---
 rtl/cfa_window_assembler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/cfa_window_assembler.sv
// CFA read-side window assembler: stages returned samples into filterSize-wide
// columns and presents filterSize x filterSize windows. Optional: CFA_ZERO_PAD_EN.
module cfa_window_assembler #(
    parameter int pixelBitWidth = 8,
    parameter int filterSize    = 5,
    parameter int rowBitWidth   = 11,
    parameter int colBitWidth   = 11
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    input  logic [rowBitWidth-1:0]                         rowMax,
    input  logic [colBitWidth-1:0]                         colMax,
    input  logic [pixelBitWidth-1:0]                       pixIn,
    input  logic                                           pixValid,
    input  logic                                           pixInBounds,
    input  logic                                           windowReady,
    output logic [filterSize*filterSize*pixelBitWidth-1:0] window,
    output logic                                           windowValid,
    output logic [rowBitWidth-1:0]                         outRow,
    output logic [colBitWidth-1:0]                         outCol,
    output logic                                           en,
    output logic                                           frameDone,
    output logic                                           overflow
);
    localparam int CW  = filterSize * pixelBitWidth;
    localparam int WW  = filterSize * CW;
    localparam int SCW = $clog2(filterSize);
    localparam int FCW = $clog2(filterSize + 1);

    typedef enum logic [2:0] {IDLE, FILL, STREAM, HOLD, DONE} state_t;

    state_t                   state;
    logic [CW-1:0]            stage;
    logic [SCW-1:0]           stageCnt;
    logic [FCW-1:0]           fillCnt;
    logic                     colPending;
    logic [rowBitWidth-1:0]   rowLast;
    logic [colBitWidth-1:0]   colLast;
    logic [pixelBitWidth-1:0] sp;
    logic [CW-1:0]            colVec;
    logic [CW-1:0]            commitCol;
    logic                     active;
    logic                     accept;
    logic                     drop;
    logic                     colDone;
    logic                     atLastCol;
    logic                     atLastRow;

`ifdef CFA_ZERO_PAD_EN
    assign sp = pixInBounds ? pixIn : '0;
`else
    logic unusedInBounds;
    assign unusedInBounds = pixInBounds;
    assign sp = pixIn;
`endif

    function automatic logic [WW-1:0] shiftIn(
        input logic [WW-1:0] w,
        input logic [CW-1:0] c
    );
        return {c, w[WW-1:CW]};
    endfunction

    assign active  = (state == FILL) || (state == STREAM) || (state == HOLD);
    assign accept  = pixValid && active && !colPending;
    assign drop    = pixValid && active && colPending;
    assign colDone = accept && (stageCnt == SCW'(filterSize - 1));

    assign atLastCol = (outCol == colLast);
    assign atLastRow = (outRow == rowLast);

    // The completing sample is not yet in the staging register.
    always_comb begin
        colVec = stage;
        colVec[(filterSize-1)*pixelBitWidth +: pixelBitWidth] = sp;
    end

    assign commitCol = colPending ? stage : colVec;

    assign en = !((state == HOLD) && !windowReady) && !colPending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            stage       <= '0;
            stageCnt    <= '0;
            fillCnt     <= '0;
            colPending  <= 1'b0;
            rowLast     <= '0;
            colLast     <= '0;
            window      <= '0;
            windowValid <= 1'b0;
            outRow      <= '0;
            outCol      <= '0;
            frameDone   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            if (start) begin
                state       <= FILL;
                stage       <= '0;
                stageCnt    <= '0;
                fillCnt     <= '0;
                colPending  <= 1'b0;
                windowValid <= 1'b0;
                outRow      <= '0;
                outCol      <= '0;
                frameDone   <= 1'b0;
                rowLast     <= rowMax - rowBitWidth'(1);
                colLast     <= colMax - colBitWidth'(1);
            end else begin
                if (accept) begin
                    stage[stageCnt*pixelBitWidth +: pixelBitWidth] <= sp;
                    stageCnt <= colDone ? '0 : stageCnt + SCW'(1);
                end
                unique case (state)
                    FILL: begin
                        if (colDone) begin
                            window <= shiftIn(window, colVec);
                            if (fillCnt == FCW'(filterSize - 1)) begin
                                state       <= HOLD;
                                windowValid <= 1'b1;
                                fillCnt     <= '0;
                            end else begin
                                fillCnt <= fillCnt + FCW'(1);
                            end
                        end
                    end
                    STREAM: begin
                        if (colDone) begin
                            window      <= shiftIn(window, colVec);
                            state       <= HOLD;
                            windowValid <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (windowReady) begin
                            windowValid <= 1'b0;
                            colPending  <= 1'b0;
                            if (atLastRow && atLastCol) begin
                                state     <= DONE;
                                frameDone <= 1'b1;
                                stageCnt  <= '0;
                            end else if (atLastCol) begin
                                state  <= FILL;
                                outRow <= outRow + rowBitWidth'(1);
                                outCol <= '0;
                                if (colPending || colDone) begin
                                    window  <= shiftIn(window, commitCol);
                                    fillCnt <= FCW'(1);
                                end else begin
                                    fillCnt <= '0;
                                end
                            end else begin
                                outCol <= outCol + colBitWidth'(1);
                                // A ready column yields the next window at once.
                                if (colPending || colDone) begin
                                    window      <= shiftIn(window, commitCol);
                                    windowValid <= 1'b1;
                                end else begin
                                    state <= STREAM;
                                end
                            end
                        end else if (colDone) begin
                            colPending <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
